// File: rtl/idma_write_ibuffer_mb.sv
// idma_write_ibuffer_mb: writes a strided DMA beat stream into a banked ibuffer
// through a single registered output slot; bank = low address bits.
module idma_write_ibuffer_mb #(
  parameter int DATA_WIDTH = 128,
  parameter int MEM_AW     = 15,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int NUM_BANK   = 2,
  localparam int BANK_AW   = NUM_BANK > 1 ? $clog2(NUM_BANK) : 0,
  localparam int BW        = BANK_AW > 0 ? BANK_AW : 1,
  localparam int IAW       = MEM_AW - BANK_AW
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic [MEM_AW-1:0]     cfg_base_addr,
  input  logic [MEM_AW-1:0]     cfg_stride,
  input  logic [MEM_AW-1:0]     cfg_data_num,
  input  logic                  dma_rd_data_valid,
  input  logic [DATA_WIDTH-1:0] dma_rd_data,
  input  logic [STRB_WIDTH-1:0] dma_rd_strb,
  output logic                  dma_rd_data_ready,
  output logic [NUM_BANK-1:0]   ibuffer_cen,
  input  logic [NUM_BANK-1:0]   ibuffer_ready,
  output logic                  ibuffer_wen,
  output logic [IAW-1:0]        ibuffer_addr,
  output logic [DATA_WIDTH-1:0] ibuffer_wdata,
  output logic [STRB_WIDTH-1:0] ibuffer_strb,
  output logic                  busy,
  output logic                  dma_write_done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t                r_state;
  logic [MEM_AW-1:0]     r_acc, r_stride, r_num, r_cnt;
  logic                  r_valid, r_done;
  logic [BW-1:0]         r_bank;
  logic [IAW-1:0]        r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_strb;
  logic [BW-1:0]         w_bank;
  logic                  w_wr_ok, w_acc, w_last;
  assign w_bank  = NUM_BANK > 1 ? r_acc[BW-1:0] : '0;
  assign w_wr_ok = r_valid && ibuffer_ready[r_bank];
  // the slot may refill in the same cycle it drains, giving one beat per cycle
  assign dma_rd_data_ready = (r_state == RUN) && (!r_valid || w_wr_ok);
  assign w_acc  = dma_rd_data_valid && dma_rd_data_ready;
  assign w_last = r_cnt + 1'b1 == r_num;
  assign ibuffer_cen    = r_valid ? NUM_BANK'(1) << r_bank : '0;
  assign ibuffer_wen    = r_valid;
  assign ibuffer_addr   = r_addr;
  assign ibuffer_wdata  = r_wdata;
  assign ibuffer_strb   = r_strb;
  assign busy           = r_state != IDLE;
  assign dma_write_done = r_done;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_stride <= '0;
      r_num    <= '0;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_bank   <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_strb   <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_acc) begin
        r_valid <= 1'b1;
        r_bank  <= w_bank;
        r_addr  <= IAW'(r_acc >> BANK_AW);
        r_wdata <= dma_rd_data;
        r_strb  <= dma_rd_strb;
        r_acc   <= r_acc + r_stride;
        r_cnt   <= r_cnt + 1'b1;
      end else if (w_wr_ok) begin
        r_valid <= 1'b0;
      end
      case (r_state)
        IDLE: if (cfg_start) begin
          r_acc    <= cfg_base_addr;
          r_stride <= cfg_stride;
          r_num    <= cfg_data_num;
          r_cnt    <= '0;
          r_state  <= cfg_data_num == '0 ? DRAIN : RUN;
        end
        RUN: if (w_acc && w_last) r_state <= DRAIN;
        DRAIN: if (!r_valid || w_wr_ok) begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_idma_write_ibuffer_mb.sv
// tb_idma_write_ibuffer_mb: directed jobs on a 2-bank ibuffer writer with
// hand-computed global address lists.
module tb_idma_write_ibuffer_mb;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic         cfg_start = 1'b0;
  logic [14:0]  cfg_base_addr = '0, cfg_stride = '0, cfg_data_num = '0;
  logic         dma_rd_data_valid = 1'b0;
  logic [127:0] dma_rd_data = '0;
  logic [15:0]  dma_rd_strb = '0;
  logic         dma_rd_data_ready;
  logic [1:0]   ibuffer_cen;
  logic [1:0]   ibuffer_ready = 2'b11;
  logic         ibuffer_wen;
  logic [13:0]  ibuffer_addr;
  logic [127:0] ibuffer_wdata;
  logic [15:0]  ibuffer_strb;
  logic         busy, dma_write_done;
  int total = 0, bad = 0;
  typedef struct {logic [1:0] cen; logic [13:0] addr; logic [63:0] d; logic [15:0] st; int c;} wr_t;
  wr_t wq[$];
  logic [14:0] eq[$];
  idma_write_ibuffer_mb dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
    .cfg_stride(cfg_stride), .cfg_data_num(cfg_data_num),
    .dma_rd_data_valid(dma_rd_data_valid), .dma_rd_data(dma_rd_data),
    .dma_rd_strb(dma_rd_strb), .dma_rd_data_ready(dma_rd_data_ready),
    .ibuffer_cen(ibuffer_cen), .ibuffer_ready(ibuffer_ready), .ibuffer_wen(ibuffer_wen),
    .ibuffer_addr(ibuffer_addr), .ibuffer_wdata(ibuffer_wdata), .ibuffer_strb(ibuffer_strb),
    .busy(busy), .dma_write_done(dma_write_done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [8:0] outs();
    return {ibuffer_cen, ibuffer_wen, |ibuffer_addr, |ibuffer_wdata, |ibuffer_strb,
            dma_rd_data_ready, busy, dma_write_done};
  endfunction
  task automatic run_job(input string nm, input logic [14:0] b, input logic [14:0] s,
                         input logic [14:0] n, input int stall, input logic [1:0] mask,
                         input bit mid, input int abort);
    int k = 0, cyc = 0, sl = stall, dn = 0, dcyc = -1, bcnt = 0, unst = 0, rdy_bad = 0;
    bit acc, fin = 0;
    logic [1:0] sc = '0;
    logic [13:0] sa = '0;
    logic [127:0] sd = '0;
    wq.delete();
    @(posedge clk); #1;
    cfg_base_addr = b; cfg_stride = s; cfg_data_num = n; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    while (!fin && cyc < 80) begin
      cfg_start = mid && cyc == 2;
      cfg_base_addr = mid ? 15'h500 : b;
      dma_rd_data_valid = k < int'(n);
      dma_rd_data = {4{32'hC0DE_0000 | 32'(k)}};
      dma_rd_strb = 16'(k);
      @(negedge clk);
      if (ibuffer_wen && sl > 0) begin
        ibuffer_ready = 2'b00;
        if (sl == stall) begin sc = ibuffer_cen; sa = ibuffer_addr; sd = ibuffer_wdata; end
        unst += int'({sc, sa, sd} !== {ibuffer_cen, ibuffer_addr, ibuffer_wdata});
        sl--;
      end else ibuffer_ready = mask;
      #1;
      if (ibuffer_ready == 2'b00 && dma_rd_data_ready) rdy_bad++;
      acc = dma_rd_data_valid && dma_rd_data_ready;
      bcnt += int'(busy);
      if (ibuffer_wen && |(ibuffer_cen & ibuffer_ready))
        wq.push_back('{ibuffer_cen, ibuffer_addr, ibuffer_wdata[63:0], ibuffer_strb, cyc});
      if (dma_write_done) begin dn++; dcyc = cyc; fin = 1; end
      if (abort > 0 && wq.size() == abort) begin
        rst_n = 1'b0;
        #1;
        check({nm, "_rst_outs"}, 64'(outs()), 0);
        dma_rd_data_valid = 1'b0;
        cfg_start = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (acc) k++;
      cyc++;
    end
    cfg_start = 1'b0;
    dma_rd_data_valid = 1'b0;
    ibuffer_ready = 2'b11;
    repeat (3) begin
      @(negedge clk); #1;
      if (dma_write_done) dn++;
      if (ibuffer_wen) wq.push_back('{ibuffer_cen, ibuffer_addr, ibuffer_wdata[63:0], ibuffer_strb, -1});
      @(posedge clk); #1;
    end
    check({nm, "_nwr"}, 64'(wq.size()), 64'(n));
    check({nm, "_done_cnt"}, 64'(dn), 1);
    check({nm, "_busy_end"}, 64'(busy), 0);
    for (int i = 0; i < wq.size() && i < eq.size(); i++) begin
      check($sformatf("%s_cen%0d", nm, i), 64'(wq[i].cen), 64'(2'b01 << eq[i][0]));
      check($sformatf("%s_addr%0d", nm, i), 64'(wq[i].addr), 64'(eq[i][14:1]));
      check($sformatf("%s_data%0d", nm, i), wq[i].d, {2{32'hC0DE_0000 | 32'(i)}});
      check($sformatf("%s_strb%0d", nm, i), 64'(wq[i].st), 64'(i));
    end
    if (n == 0) check({nm, "_busy_cycles"}, 64'(bcnt), 1);
    if (n > 0 && wq.size() > 0) begin
      check({nm, "_first_cyc"}, 64'(wq[0].c), 64'(1 + stall));
      check({nm, "_done_gap"}, 64'(dcyc - wq[wq.size()-1].c), 1);
    end
    if (n > 0 && wq.size() > 0 && stall == 0)
      check({nm, "_b2b"}, 64'(wq[wq.size()-1].c - wq[0].c), 64'(n - 1));
    if (stall > 0) begin
      check({nm, "_unstable"}, 64'(unst), 0);
      check({nm, "_ready_in_stall"}, 64'(rdy_bad), 0);
    end
  endtask
  initial begin
    int dn;
    dma_rd_data_valid = 1'b1;
    #12;
    check("reset_outs", 64'(outs()), 0);
    dma_rd_data_valid = 1'b0;
    rst_n = 1'b1;
    eq = '{15'h10, 15'h11, 15'h12, 15'h13};
    run_job("seq", 15'h10, 15'd1, 15'd4, 0, 2'b11, 0, 0);
    eq = '{15'h7FFE, 15'h7FFF, 15'h0000};
    run_job("wrap", 15'h7FFE, 15'd1, 15'd3, 0, 2'b11, 0, 0);
    eq = '{15'h40, 15'h43, 15'h46};
    run_job("stall", 15'h40, 15'd3, 15'd3, 3, 2'b11, 0, 0);
    eq = '{15'h100, 15'h102, 15'h104, 15'h106};
    run_job("mid", 15'h100, 15'd2, 15'd4, 0, 2'b01, 1, 0);
    eq = '{};
    run_job("zero", 15'h55, 15'd1, 15'd0, 0, 2'b11, 0, 0);
    eq = '{15'h20, 15'h21};
    run_job("abort", 15'h20, 15'd1, 15'd5, 0, 2'b11, 0, 2);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ibuffer_ready = 2'b11;
    dn = 0;
    repeat (6) begin
      @(negedge clk);
      dn += int'(dma_write_done);
    end
    check("abort_no_done", 64'(dn), 0);
    check("abort_idle", 64'(busy), 0);
    eq = '{15'h31, 15'h32};
    run_job("after", 15'h31, 15'd1, 15'd2, 0, 2'b11, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
